// File: rtl/cr_clic_int_req_ctrl.sv
// CLIC interrupt request controller: gates the arbitrated candidate and presents
// a registered valid/ack request to the core. It also issues the claim pulse and the post-claim hold-off.
//
// state | meaning
// IDLE  | no request presented, evaluating the arbiter candidate
// REQ   | request valid to core, payload tracks the arbiter each cycle
// CLAIM | core acked; one-cycle clear pulse to the kid array
// HOLD  | waiting for the arbiter result to settle after the claim
module cr_clic_int_req_ctrl #(
    parameter int ID_WIDTH  = 12,
    parameter int IL_WIDTH  = 8,
    parameter int CLR_WAIT  = 2,
    parameter int CNT_WIDTH = 4
) (
    input  logic                out_clk,
    input  logic                cpurst,
    input  logic [ID_WIDTH-1:0] arb_ctrl_int_id,
    input  logic [IL_WIDTH-1:0] arb_ctrl_int_il,
    input  logic                arb_ctrl_int_hv,
    input  logic                arb_ctrl_int_mode,
    input  logic [IL_WIDTH-1:0] ctrl_int_th,
    input  logic [IL_WIDTH-1:0] cpu_clic_cur_il,
    input  logic                cpu_clic_ie,
    input  logic                cpu_clic_int_ack,
    output logic                clic_cpu_int_vld,
    output logic [ID_WIDTH-1:0] clic_cpu_int_id,
    output logic [IL_WIDTH-1:0] clic_cpu_int_il,
    output logic                clic_cpu_int_hv,
    output logic                clic_cpu_int_mode,
    output logic                ctrl_kid_clr_vld,
    output logic [ID_WIDTH-1:0] ctrl_kid_clr_id,
    output logic                ctrl_clk_en
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        CLAIM = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CLR_LOAD = CNT_WIDTH'(CLR_WAIT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t                state, state_nxt;
    logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
    logic                  eligible;

    logic                  vld_nxt;
    logic [ID_WIDTH-1:0]   id_nxt;
    logic [IL_WIDTH-1:0]   il_nxt;
    logic                  hv_nxt;
    logic                  mode_nxt;
    logic                  clr_vld_nxt;
    logic [ID_WIDTH-1:0]   clr_id_nxt;
    logic                  clk_en_nxt;

    assign eligible = cpu_clic_ie
                    & (arb_ctrl_int_il != '0)
                    & (arb_ctrl_int_il > ctrl_int_th)
                    & (arb_ctrl_int_il > cpu_clic_cur_il);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        vld_nxt     = 1'b0;
        id_nxt      = '0;
        il_nxt      = '0;
        hv_nxt      = 1'b0;
        mode_nxt    = 1'b0;
        clr_vld_nxt = 1'b0;
        clr_id_nxt  = '0;

        case (state)
            IDLE: begin
                if (eligible) begin
                    state_nxt = REQ;
                    vld_nxt   = 1'b1;
                    id_nxt    = arb_ctrl_int_id;
                    il_nxt    = arb_ctrl_int_il;
                    hv_nxt    = arb_ctrl_int_hv;
                    mode_nxt  = arb_ctrl_int_mode;
                end
            end
            REQ: begin
                // An ack claims the payload currently on the outputs, even if the
                // candidate became ineligible in the same cycle.
                if (cpu_clic_int_ack) begin
                    state_nxt   = CLAIM;
                    clr_vld_nxt = 1'b1;
                    clr_id_nxt  = clic_cpu_int_id;
                    cnt_nxt     = CLR_LOAD;
                end else if (!eligible) begin
                    state_nxt = IDLE;
                end else begin
                    vld_nxt  = 1'b1;
                    id_nxt   = arb_ctrl_int_id;
                    il_nxt   = arb_ctrl_int_il;
                    hv_nxt   = arb_ctrl_int_hv;
                    mode_nxt = arb_ctrl_int_mode;
                end
            end
            CLAIM, HOLD: begin
                // Hold-off is counted from the claim cycle so a new request can
                // appear CLR_WAIT+2 cycles after the ack at the earliest.
                if (cnt <= CNT_ONE) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = HOLD;
                    cnt_nxt   = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        clk_en_nxt = (state_nxt != IDLE) | (arb_ctrl_int_il != '0);
    end

    always_ff @(posedge out_clk) begin
        if (cpurst) begin
            state             <= IDLE;
            cnt               <= '0;
            clic_cpu_int_vld  <= 1'b0;
            clic_cpu_int_id   <= '0;
            clic_cpu_int_il   <= '0;
            clic_cpu_int_hv   <= 1'b0;
            clic_cpu_int_mode <= 1'b0;
            ctrl_kid_clr_vld  <= 1'b0;
            ctrl_kid_clr_id   <= '0;
            ctrl_clk_en       <= 1'b0;
        end else begin
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            clic_cpu_int_vld  <= vld_nxt;
            clic_cpu_int_id   <= id_nxt;
            clic_cpu_int_il   <= il_nxt;
            clic_cpu_int_hv   <= hv_nxt;
            clic_cpu_int_mode <= mode_nxt;
            ctrl_kid_clr_vld  <= clr_vld_nxt;
            ctrl_kid_clr_id   <= clr_id_nxt;
            ctrl_clk_en       <= clk_en_nxt;
        end
    end

endmodule
